spi_slave: RTL and testbench

Oversampled SPI responder (slave) that sits on the far end of the team's `spi_master` bus, typically in a test FPGA or auxiliary device emulating a peripheral. It synchronises SPI_CLK, SPI_SS and MOSI into the CLK_IN domain, receives a C-bit word from MOSI and simultaneously returns a preloaded C-bit word on MISO. Bit order matches the master: MOSI is received LSB-first and MISO is transmitted MSB-first. It supports all four CPOL/CPHA modes.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_slave.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder slice.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    // Modes are encoded as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_C_DEFAULT    = 32;
    localparam int SPI_SYNC_DEFAULT = 2;

    // A leading edge leaves the idle level given by cpol.
    function automatic logic is_leading(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop synchroniser for the asynchronous SPI pins.
module spi_sync
    import spi_pkg::*;
#(
    parameter int           W           = 1,
    parameter int           SYNC_STAGES = SPI_SYNC_DEFAULT,
    parameter logic [W-1:0] RST_VAL     = '0
) (
    input  logic         CLK_IN,
    input  logic         RST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [SYNC_STAGES];

    // Synchroniser chain, reset to the pins' idle levels
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI responder: LSB-first receive on MOSI, MSB-first transmit on MISO,
// all four CPOL/CPHA modes, with abort and TX-underrun reporting.
module spi_slave
    import spi_pkg::*;
#(
    parameter int C           = SPI_C_DEFAULT,
    parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
    input  logic         CLK_IN,
    input  logic         RST,
    input  logic         SPI_CLK,
    input  logic         SPI_SS,
    input  logic         MOSI,
    output logic         MISO,
    output logic         MISO_OE,
    input  logic         CPOL,
    input  logic         CPHA,
    input  logic [C-1:0] din,
    input  logic         load,
    output logic [C-1:0] dout,
    output logic         valid,
    output logic         abort,
    output logic         tx_underrun,
    output logic         busy
);

    localparam int            CW       = $clog2(C + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(C);

    logic [2:0]             sync_s;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_hist_r, sclk_hist_r;
    logic [SYNC_STAGES-1:0] settle_r;
    logic                   armed_r, armed_next_s;

    logic                   ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;
    logic                   lead_s, trail_s, sample_s, shift_s;

    spi_state_e             state_r, state_next_s;
    logic                   cpol_r, cpol_next_s, cpha_r, cpha_next_s;
    logic [C-1:0]           hold_r, hold_next_s;
    logic [C-1:0]           tx_r, tx_next_s;
    logic [C-1:0]           rx_r, rx_next_s;
    logic [C-1:0]           dout_r, dout_next_s;
    logic [CW-1:0]          cnt_r, cnt_next_s;
    logic                   loaded_r, loaded_next_s;
    logic                   busy_r, busy_next_s;
    logic                   miso_r, miso_next_s;
    logic                   valid_r, valid_next_s;
    logic                   abort_r, abort_next_s;
    logic                   underrun_r, underrun_next_s;

    spi_sync #(
        .W           (3),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (3'b100)
    ) u_sync (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .d      ({SPI_SS, SPI_CLK, MOSI}),
        .q      (sync_s)
    );

    assign ss_s   = sync_s[2];
    assign sclk_s = sync_s[1];
    assign mosi_s = sync_s[0];

    // SS-fall is only trusted once the chain holds real pin values and SS was seen high,
    // so a reset taken while selected does not fake a new transfer.
    assign ss_fall_s   = armed_r & ss_hist_r & ~ss_s;
    assign ss_rise_s   = ~ss_hist_r & ss_s;
    assign sclk_rise_s = ~sclk_hist_r & sclk_s;
    assign sclk_fall_s = sclk_hist_r & ~sclk_s;
    assign lead_s      = is_leading(cpol_r, sclk_rise_s, sclk_fall_s);
    assign trail_s     = is_leading(~cpol_r, sclk_rise_s, sclk_fall_s);
    assign sample_s    = cpha_r ? trail_s : lead_s;
    assign shift_s     = cpha_r ? (lead_s & (cnt_r != {CW{1'b0}})) : trail_s;

    // Next-state and datapath decode
    always_comb begin
        state_next_s    = state_r;
        cpol_next_s     = cpol_r;
        cpha_next_s     = cpha_r;
        tx_next_s       = tx_r;
        rx_next_s       = rx_r;
        dout_next_s     = dout_r;
        cnt_next_s      = cnt_r;
        busy_next_s     = busy_r;
        valid_next_s    = 1'b0;
        abort_next_s    = 1'b0;
        underrun_next_s = 1'b0;
        hold_next_s     = load ? din : hold_r;
        loaded_next_s   = loaded_r | load;
        armed_next_s    = armed_r | (settle_r[SYNC_STAGES-1] & ss_s);

        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_next_s    = ST_SHIFT;
                    cpol_next_s     = CPOL;
                    cpha_next_s     = CPHA;
                    tx_next_s       = hold_r;
                    rx_next_s       = {C{1'b0}};
                    cnt_next_s      = {CW{1'b0}};
                    busy_next_s     = 1'b1;
                    underrun_next_s = ~loaded_r;
                    loaded_next_s   = load;
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_FULL) begin
                    dout_next_s  = rx_r;
                    valid_next_s = 1'b1;
                    if (ss_rise_s) begin
                        state_next_s = ST_IDLE;
                        busy_next_s  = 1'b0;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                    busy_next_s  = 1'b0;
                    abort_next_s = 1'b1;
                end else if (sample_s) begin
                    rx_next_s  = {mosi_s, rx_r[C-1:1]};
                    cnt_next_s = cnt_r + CW'(1);
                end else if (shift_s) begin
                    tx_next_s = {tx_r[C-2:0], 1'b0};
                end else begin
                    tx_next_s = tx_r;
                end
            end
            ST_DONE: begin
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                    busy_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                busy_next_s  = 1'b0;
            end
        endcase

        miso_next_s = (busy_r && (state_r == ST_SHIFT)) ? tx_r[C-1] : 1'b0;
    end

    // State, datapath and output registers
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            ss_hist_r   <= 1'b1;
            sclk_hist_r <= 1'b0;
            settle_r    <= {SYNC_STAGES{1'b0}};
            armed_r     <= 1'b0;
            state_r     <= ST_IDLE;
            cpol_r      <= 1'b0;
            cpha_r      <= 1'b0;
            hold_r      <= {C{1'b0}};
            tx_r        <= {C{1'b0}};
            rx_r        <= {C{1'b0}};
            dout_r      <= {C{1'b0}};
            cnt_r       <= {CW{1'b0}};
            loaded_r    <= 1'b0;
            busy_r      <= 1'b0;
            miso_r      <= 1'b0;
            valid_r     <= 1'b0;
            abort_r     <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            ss_hist_r   <= ss_s;
            sclk_hist_r <= sclk_s;
            settle_r    <= {settle_r[SYNC_STAGES-2:0], 1'b1};
            armed_r     <= armed_next_s;
            state_r     <= state_next_s;
            cpol_r      <= cpol_next_s;
            cpha_r      <= cpha_next_s;
            hold_r      <= hold_next_s;
            tx_r        <= tx_next_s;
            rx_r        <= rx_next_s;
            dout_r      <= dout_next_s;
            cnt_r       <= cnt_next_s;
            loaded_r    <= loaded_next_s;
            busy_r      <= busy_next_s;
            miso_r      <= miso_next_s;
            valid_r     <= valid_next_s;
            abort_r     <= abort_next_s;
            underrun_r  <= underrun_next_s;
        end
    end

    assign MISO        = miso_r;
    assign MISO_OE     = busy_r;
    assign busy        = busy_r;
    assign dout        = dout_r;
    assign valid       = valid_r;
    assign abort       = abort_r;
    assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave driving a behavioural SPI master.
module tb_spi_slave;

    localparam int C           = 32;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 8;

    logic         CLK_IN = 1'b0;
    logic         RST;
    logic         SPI_CLK, SPI_SS, MOSI, CPOL, CPHA, load;
    logic         MISO, MISO_OE, valid, abort, tx_underrun, busy;
    logic [C-1:0] din, dout;

    spi_slave #(.C(C), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK_IN      (CLK_IN),
        .RST         (RST),
        .SPI_CLK     (SPI_CLK),
        .SPI_SS      (SPI_SS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .MISO_OE     (MISO_OE),
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .din         (din),
        .load        (load),
        .dout        (dout),
        .valid       (valid),
        .abort       (abort),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 CLK_IN = ~CLK_IN;

    int           checks = 0;
    int           errors = 0;
    int           v_cnt = 0;
    int           a_cnt = 0;
    int           u_cnt = 0;
    logic [C-1:0] exp_q [$];
    logic [C-1:0] mon_exp;
    logic [C-1:0] hold_m = '0;
    bit           loaded_m = 1'b0;
    logic [C-1:0] last_dout_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic do_load(input logic [C-1:0] w);
        din  = w;
        load = 1'b1;
        wait_cyc(1);
        load     = 1'b0;
        hold_m   = w;
        loaded_m = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_miso",     64'(MISO),        64'(0));
        check("rst_miso_oe",  64'(MISO_OE),     64'(0));
        check("rst_dout",     64'(dout),        64'(0));
        check("rst_valid",    64'(valid),       64'(0));
        check("rst_abort",    64'(abort),       64'(0));
        check("rst_underrun", 64'(tx_underrun), 64'(0));
        check("rst_busy",     64'(busy),        64'(0));
    endtask

    // One master transaction of nbits clocks; rst_at >= 0 pulses RST before that bit.
    task automatic xfer(input logic [1:0] mode, input logic [C-1:0] w, input int nbits, input int rst_at);
        logic         cpol, cpha, extra;
        logic [C-1:0] rx_m, tx_exp;
        bit           und_exp, was_rst, full;
        int           v0, a0, u0;
        cpol     = mode[1];
        cpha     = mode[0];
        tx_exp   = hold_m;
        und_exp  = !loaded_m;
        loaded_m = 1'b0;
        v0 = v_cnt; a0 = a_cnt; u0 = u_cnt;
        rx_m = '0; extra = 1'b0; was_rst = 1'b0;
        full = (nbits >= C) && (rst_at < 0);
        CPOL = cpol; CPHA = cpha; SPI_CLK = cpol;
        wait_cyc(H);
        if (full) begin
            exp_q.push_back(w);
            last_dout_m = w;
        end
        SPI_SS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                RST = 1'b1;
                #1;
                check_reset_outputs();
                wait_cyc(2);
                RST = 1'b0;
                SPI_SS = 1'b1;
                hold_m = '0; loaded_m = 1'b0; last_dout_m = '0;
                was_rst = 1'b1;
                break;
            end
            if (!cpha) MOSI = (i < C) ? w[i] : 1'($urandom);
            wait_cyc(H);
            if (!cpha) begin
                if (i < C) rx_m[C-1-i] = MISO; else extra = extra | MISO;
            end
            SPI_CLK = ~cpol;
            if (cpha) MOSI = (i < C) ? w[i] : 1'($urandom);
            if (i == 1) check("miso_oe_selected", 64'(MISO_OE), 64'(1));
            wait_cyc(H);
            if (cpha) begin
                if (i < C) rx_m[C-1-i] = MISO; else extra = extra | MISO;
            end
            SPI_CLK = cpol;
        end
        wait_cyc(H);
        SPI_SS = 1'b1;
        MOSI   = 1'b0;
        wait_cyc(3 * H);
        check("miso_oe_idle",   64'(MISO_OE),     64'(0));
        check("busy_idle",      64'(busy),        64'(0));
        check("valid_count",    64'(v_cnt - v0),  64'(full ? 1 : 0));
        check("abort_count",    64'(a_cnt - a0),  64'((nbits < C && !was_rst) ? 1 : 0));
        check("underrun_count", 64'(u_cnt - u0),  64'(und_exp ? 1 : 0));
        check("dout_hold",      64'(dout),        64'(last_dout_m));
        if (full) check("miso_word", 64'(rx_m), 64'(tx_exp));
        if (nbits > C) check("miso_after_done", 64'(extra), 64'(0));
    endtask

    initial begin
        RST = 1'b1; SPI_CLK = 1'b0; SPI_SS = 1'b1; MOSI = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; din = '0; load = 1'b0;
        fork
            forever begin
                @(negedge CLK_IN);
                if (valid) begin
                    v_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_unexpected: got valid with dout 0x%0h, required no valid", dout);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("dout_on_valid", 64'(dout), 64'(mon_exp));
                    end
                end
                if (abort) a_cnt++;
                if (tx_underrun) u_cnt++;
            end
        join_none
        wait_cyc(3);
        check_reset_outputs();
        RST = 1'b0;
        wait_cyc(10);

        for (int m = 0; m < 4; m++) begin
            do_load(32'hA5A5_0F0F);
            xfer(2'(m), 32'h1234_5678, C, -1);
        end

        do_load($urandom);
        xfer(2'b00, $urandom, 13, -1);

        do_load($urandom);
        xfer(2'b01, $urandom, C, -1);
        xfer(2'b01, $urandom, C, -1);

        do_load($urandom);
        xfer(2'b00, $urandom, 40, -1);
        do_load($urandom);
        xfer(2'b11, $urandom, 40, -1);

        do_load($urandom);
        xfer(2'b00, $urandom, C, 16);
        wait_cyc(20);
        do_load($urandom);
        xfer(2'b00, $urandom, C, -1);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) do_load($urandom);
            xfer(2'($urandom_range(0, 3)), $urandom, C, -1);
        end

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

endmodule
